// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES downstream reset domains in ascending order,
// waiting for each stage's ack with a bounded timeout and a fixed gap between stages.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  sw_rst_req_i,
    input  logic [NUM_STAGES-1:0] stage_ack_i,
    output logic [NUM_STAGES-1:0] stage_rst_no,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES)
                        ? ((HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT)
                        : ((GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT);
    localparam int CW = $clog2(MAXC + 1);
    localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {HOLD, WAIT_ACK, GAP, DONE, ERROR} state_t;

    state_t                r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [KW-1:0]         r_k, w_k;
    logic [NUM_STAGES-1:0] r_rst_n, w_rst_n;
    logic                  r_busy, r_done, r_timeout;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_k     = r_k;
        w_rst_n = r_rst_n;
        if (sw_rst_req_i) begin
            w_state = HOLD;
            w_cnt   = '0;
            w_k     = '0;
            w_rst_n = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                        w_state = WAIT_ACK;
                        w_cnt   = '0;
                        w_k     = '0;
                        w_rst_n = NUM_STAGES'(1);
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // An ack on the final wait edge still counts as an ack.
                    if (stage_ack_i[r_k]) begin
                        w_state = (r_k == KW'(NUM_STAGES - 1)) ? DONE : GAP;
                        w_cnt   = '0;
                    end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        w_state = ERROR;
                        w_cnt   = '0;
                        w_rst_n = '0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                        w_state = WAIT_ACK;
                        w_cnt   = '0;
                        w_k     = r_k + 1'b1;
                        w_rst_n = r_rst_n | (NUM_STAGES'(1) << (r_k + 1'b1));
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                DONE:    w_rst_n = '1;
                ERROR:   w_rst_n = '0;
                default: w_state = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_k       <= '0;
            r_rst_n   <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_k       <= w_k;
            r_rst_n   <= w_rst_n;
            r_busy    <= (w_state == HOLD) || (w_state == WAIT_ACK) || (w_state == GAP);
            r_done    <= (w_state == DONE);
            r_timeout <= (w_state == ERROR);
        end
    end

    assign stage_rst_no = r_rst_n;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks of reset_sequencer against a
// timeline model that schedules releases from ack arrival edges.
module tb_reset_sequencer;
    localparam int NS = 3;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          sw_rst_req_i = 1'b0;
    logic [NS-1:0] stage_ack_i = '0;
    logic [NS-1:0] stage_rst_no;
    logic          busy_o, done_o, timeout_o;
    logic [5:0]    obs, exp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [NS-1:0] ack_at [0:255];
    logic          sw_at  [0:255];

    reset_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(H), .GAP_CYCLES(G), .ACK_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_ni(rst_ni), .sw_rst_req_i(sw_rst_req_i), .stage_ack_i(stage_ack_i),
        .stage_rst_no(stage_rst_no), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    assign obs = {stage_rst_no, busy_o, done_o, timeout_o};

    // Expected {stage_rst_no, busy, done, timeout} after edge e, derived by scheduling:
    // hold window, then per stage an ack window of T edges followed by a G-edge gap.
    function automatic logic [5:0] model(input int e);
        int s, t, a;
        logic [NS-1:0] rel;
        s = 0;
        for (int i = 1; i <= e; i++) if (sw_at[i]) s = i;
        t = s + H;
        if (e < t) return 6'b000_100;
        rel = 3'b001;
        for (int k = 0; k < NS; k++) begin
            a = 0;
            for (int j = t + 1; j <= t + T; j++) if (a == 0 && j <= e && ack_at[j][k]) a = j;
            if (a == 0) return (e >= t + T) ? 6'b000_001 : {rel, 3'b100};
            if (k == NS - 1) return 6'b111_010;
            if (e < a + G) return {rel, 3'b100};
            rel = rel | 3'(1 << (k + 1));
            t = a + G;
        end
        return {rel, 3'b100};
    endfunction

    task automatic tick(input logic [NS-1:0] a, input logic s);
        stage_ack_i      = a;
        sw_rst_req_i     = s;
        ack_at[cyc + 1]  = a;
        sw_at[cyc + 1]   = s;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        stage_ack_i  = '0;
        sw_rst_req_i = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ack_at[i] = '0;
            sw_at[i]  = 1'b0;
        end
        cyc = 0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000_100) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", obs, 6'b000_100);
        end
        stage_ack_i = 3'b111;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 6'b000_100) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", obs, 6'b000_100);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(3'b111, 1'b0);
            exp = model(cyc);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(3'b111, 1'b0);
            exp = model(cyc);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (cyc == 4 || cyc == 7 || cyc == 10 || cyc == 11) begin
                exp = (cyc == 4) ? 6'b001_100 : (cyc == 7) ? 6'b011_100
                    : (cyc == 10) ? 6'b111_100 : 6'b111_010;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL nominal_fixed cyc=%0d got=%b exp=%b", cyc, obs, exp);
                end
            end
        end
    endtask

    task automatic test_timeout_recovery();
        do_reset();
        for (int i = 0; i < 33; i++) begin
            tick((cyc + 1 >= 20) ? 3'b111 : 3'b101, cyc + 1 == 20);
            exp = model(cyc);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (cyc == 7 || cyc == 15 || cyc == 19 || cyc == 20 || cyc == 24 || cyc == 31) begin
                exp = (cyc == 7) ? 6'b011_100 : (cyc == 15 || cyc == 19) ? 6'b000_001
                    : (cyc == 20) ? 6'b000_100 : (cyc == 24) ? 6'b001_100 : 6'b111_010;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL timeout_fixed cyc=%0d got=%b exp=%b", cyc, obs, exp);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) tick(3'b111, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000_100) begin
            errors++;
            $display("FAIL midseq_reset got=%b exp=%b", obs, 6'b000_100);
        end
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick(3'b111, 1'b0);
            exp = model(cyc);
            checks++;
            if (obs !== exp || (cyc == 4 && obs !== 6'b001_100)) begin
                errors++;
                $display("FAIL midseq_restart cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            tick((cyc + 1 <= 10) ? 3'b001 : (cyc + 1 == 20) ? 3'b010
                 : (cyc + 1 >= 21) ? 3'b100 : 3'b000, cyc + 1 == 5);
            exp = model(cyc);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL simult cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (cyc == 5 || cyc == 20 || cyc == 22 || cyc == 23) begin
                exp = (cyc == 5) ? 6'b000_100 : (cyc == 20) ? 6'b011_100
                    : (cyc == 22) ? 6'b111_100 : 6'b111_010;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL simult_fixed cyc=%0d got=%b exp=%b", cyc, obs, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NS-1:0] a;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                for (int b = 0; b < NS; b++) a[b] = ($urandom_range(0, 5) == 0);
                tick(a, $urandom_range(0, 39) == 0);
                exp = model(cyc);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, cyc, obs, exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_timeout_recovery();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
